// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: serial double-dabble conversion feeding a
// time-multiplexed 4-digit common-anode 7-segment display.
module bcd_display_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] HEX,
  input  logic        LD,
  output logic        READY,
  output logic        DONE,
  output logic        OVF,
  output logic [15:0] DIGITS,
  output logic [3:0]  ANODES,
  output logic [7:0]  CATHODES
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_UPD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [19:0]      acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      digits_q, digits_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       cath_q, cath_d;

  logic [19:0]      adj;
  logic [3:0]       cur_nib;
  logic             cur_lz;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [19:0] add3(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    adj      = add3(acc_q);
    case (state_q)
      S_IDLE: begin
        if (LD) begin
          shreg_d = HEX;
          acc_d   = '0;
          cnt_d   = 4'd15;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        {acc_d, shreg_d} = {adj[18:0], shreg_q, 1'b0};
        cnt_d            = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = S_UPD;
      end
      S_UPD: begin
        // Both display registers change on the same edge so the scan never mixes values.
        digits_d = acc_q[15:0];
        ovf_d    = |acc_q[19:16];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_comb begin
    cur_nib = digits_q[3:0];
    cur_lz  = 1'b0;
    case (idx_q)
      2'd0: begin cur_nib = digits_q[3:0];   cur_lz = 1'b0;                     end
      2'd1: begin cur_nib = digits_q[7:4];   cur_lz = (digits_q[15:4]  == '0); end
      2'd2: begin cur_nib = digits_q[11:8];  cur_lz = (digits_q[15:8]  == '0); end
      2'd3: begin cur_nib = digits_q[15:12]; cur_lz = (digits_q[15:12] == '0); end
      default: ;
    endcase
    an_d = ~(4'b0001 << idx_q);
    if (ovf_q)                 cath_d = SEG_DASH;
    else if (BLANK_LZ && cur_lz) cath_d = SEG_BLANK;
    else                       cath_d = seg_encode(cur_nib);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'hF;
      cath_q   <= 8'hFF;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      cath_q   <= cath_d;
    end
  end

  assign READY    = (state_q == S_IDLE);
  assign DONE     = done_q;
  assign OVF      = ovf_q;
  assign DIGITS   = digits_q;
  assign ANODES   = an_q;
  assign CATHODES = cath_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Randomized scoreboard bench for bcd_display_ctrl: decimal reference model,
// conversion results checked on DONE, display scan checked every cycle.
module tb_bcd_display_ctrl;

  localparam int SCAN = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] HEX;
  logic        LD;
  logic        READY, DONE, OVF;
  logic [15:0] DIGITS;
  logic [3:0]  ANODES;
  logic [7:0]  CATHODES;

  int checks = 0;
  int passed = 0;
  int k;
  int exp_q[$];
  int shown_v   = 0;
  bit shown_ovf = 1'b0;

  bcd_display_ctrl #(.SCAN_DIV(SCAN), .BLANK_LZ(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .HEX(HEX), .LD(LD), .READY(READY), .DONE(DONE),
    .OVF(OVF), .DIGITS(DIGITS), .ANODES(ANODES), .CATHODES(CATHODES)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic int pow10(input int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int m = v % 10000;
    return 16'(((m / 1000) << 12) | (((m / 100) % 10) << 8) | (((m / 10) % 10) << 4) | (m % 10));
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input bit ovf, input int p);
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (ovf) return 8'hBF;
    if (p > 0 && v < pow10(p)) return 8'hFF;
    return tbl[(v / pow10(p)) % 10];
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) k <= 0;
    else        k <= k + 1;
  end

  // Monitor: display scan every cycle, scoreboard pop on DONE.
  always @(negedge CLK) begin
    if (!RST_N) begin
      exp_q.delete();
      shown_v   = 0;
      shown_ovf = 1'b0;
      chk("rst_anodes", 32'(ANODES), 32'hF);
      chk("rst_cathodes", 32'(CATHODES), 32'hFF);
      chk("rst_ready", 32'(READY), 32'h1);
      chk("rst_done", 32'(DONE), 32'h0);
      chk("rst_digits", 32'(DIGITS), 32'h0);
      chk("rst_ovf", 32'(OVF), 32'h0);
    end else begin
      if (k == 0) begin
        chk("anodes_pre", 32'(ANODES), 32'hF);
      end else begin
        int p;
        p = ((k - 1) / SCAN) % 4;
        chk("anodes", 32'(ANODES), 32'(4'(~(4'b0001 << p))));
        chk("cathodes", 32'(CATHODES), 32'(exp_seg(shown_v, shown_ovf, p)));
      end
      if (DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(DONE), 32'h0);
        end else begin
          int v;
          v = exp_q.pop_front();
          chk("digits", 32'(DIGITS), 32'(to_bcd(v)));
          chk("ovf", 32'(OVF), 32'(v > 9999));
          shown_v   = v % 10000;
          shown_ovf = (v > 9999);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load(input int v, input bit inj);
    int n;
    n = 0;
    while (!READY && n < 100) begin
      @(posedge CLK); #1; n++;
    end
    chk("ready_before_load", 32'(READY), 32'h1);
    HEX = 16'(v);
    LD  = 1'b1;
    exp_q.push_back(v);
    @(posedge CLK); #1;
    LD = 1'b0;
    n  = 0;
    while (!READY && n < 40) begin
      @(posedge CLK); #1; n++;
      if (n == 2) HEX = 16'($urandom);
      if (inj && n == 4) begin LD = 1'b1; HEX = 16'd7; end
      if (inj && n == 5) LD = 1'b0;
    end
    chk("busy_cycles", 32'(n), 32'd17);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    LD    = 1'b0;
    HEX   = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    idle(40);

    load(1234, 1'b0);  idle(20);
    load(9999, 1'b0);  idle(20);
    load(10000, 1'b0); idle(20);
    load(65535, 1'b0); idle(20);
    load(205, 1'b0);   idle(20);
    load(0, 1'b0);     idle(20);
    load(42, 1'b1);    idle(20);

    for (int i = 0; i < 40; i++) begin
      int v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(10, 999);
        2:       v = $urandom_range(1000, 9999);
        default: v = $urandom_range(0, 65535);
      endcase
      load(v, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 20));
    end

    // Reset in the middle of a conversion discards it.
    load(1234, 1'b0); idle(20);
    HEX = 16'd5678;
    LD  = 1'b1;
    exp_q.push_back(5678);
    @(posedge CLK); #1;
    LD = 1'b0;
    repeat (8) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_ready", 32'(READY), 32'h1);
    chk("midrst_digits", 32'(DIGITS), 32'h0);
    chk("midrst_anodes", 32'(ANODES), 32'hF);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    idle(40);
    chk("post_rst_digits", 32'(DIGITS), 32'h0);

    load(7, 1'b0); idle(20);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
